// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: timing-configuration handshake for video_timing_gen.
// The master offers a {display, front, sync, back} horizontal word and a
// {display, bottom, sync, top} vertical word; the slave accepts or rejects it.
interface video_timing_gen_if #(
  parameter int COORD_W = 11
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [4*COORD_W-1:0]   cfg_h;
  logic [4*COORD_W-1:0]   cfg_v;
  logic                   cfg_err;

  modport master (
    output cfg_valid, cfg_h, cfg_v,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_h, cfg_v,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (hpos/vpos, syncs, active area)
// with a shadowed timing configuration that is swapped in at a frame wrap.
// Optional feature: define VTG_FRAME_CNT_EN to add the 16-bit frame_count_o
// output; without it the port and its counter are absent.
//
// Configuration FSM:
//   state    | meaning
//   CFG_IDLE | no timing pending, cfg_ready high, offers are checked
//   CFG_PEND | shadow holds an accepted timing, waiting for the frame wrap
module video_timing_gen #(
  parameter int COORD_W   = 11,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_stb_i,
  video_timing_gen_if.slave  cfg,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               display_on_o,
  output logic [COORD_W-1:0] hpos_o,
  output logic [COORD_W-1:0] vpos_o,
  output logic               line_start_o,
  output logic               frame_start_o
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_count_o
`endif
);

  // Totals carry two extra bits so four maximal fields cannot overflow.
  localparam int TW = COORD_W + 2;
  localparam int FW = 4 * COORD_W;
  localparam logic [TW-1:0] LIMIT = {2'b01, {COORD_W{1'b0}}};

  localparam logic [FW-1:0] H_DEF = {COORD_W'(H_DISPLAY), COORD_W'(H_FRONT),
                                     COORD_W'(H_SYNC),    COORD_W'(H_BACK)};
  localparam logic [FW-1:0] V_DEF = {COORD_W'(V_DISPLAY), COORD_W'(V_BOTTOM),
                                     COORD_W'(V_SYNC),    COORD_W'(V_TOP)};

  // Field index: 3 = display, 2 = front/bottom, 1 = sync, 0 = back/top.
  function automatic logic [TW-1:0] fld(input logic [FW-1:0] t, input int idx);
    return TW'(t[idx*COORD_W +: COORD_W]);
  endfunction

  function automatic logic [TW-1:0] total(input logic [FW-1:0] t);
    return fld(t, 3) + fld(t, 2) + fld(t, 1) + fld(t, 0);
  endfunction

  function automatic logic axis_ok(input logic [FW-1:0] t);
    return (fld(t, 3) != '0) && (fld(t, 1) != '0) && (total(t) <= LIMIT);
  endfunction

  typedef enum logic [0:0] {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_t;

  cfg_state_t        state_q, state_d;
  logic [FW-1:0]     act_h_q, act_h_d, act_v_q, act_v_d;
  logic [FW-1:0]     sh_h_q, sh_h_d, sh_v_q, sh_v_d;
  logic              err_q, err_d;

  logic [COORD_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic               hsync_q, vsync_q, disp_q, ls_q, fs_q;

  logic              h_last, v_last, frame_wrap, cfg_ok;
  logic [TW-1:0]     hp_n, vp_n, hs_start, hs_end, vs_start, vs_end;
  logic              hs_act, vs_act;

  assign cfg_ok     = axis_ok(cfg.cfg_h) && axis_ok(cfg.cfg_v);
  assign h_last     = ({2'b00, hpos_q} == total(act_h_q) - TW'(1));
  assign v_last     = ({2'b00, vpos_q} == total(act_v_q) - TW'(1));
  assign frame_wrap = clk_stb_i && h_last && v_last;

  // Configuration handshake and shadow/active timing next state.
  always_comb begin
    state_d = state_q;
    act_h_d = act_h_q;
    act_v_d = act_v_q;
    sh_h_d  = sh_h_q;
    sh_v_d  = sh_v_q;
    err_d   = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        if (cfg.cfg_valid) begin
          if (cfg_ok) begin
            sh_h_d  = cfg.cfg_h;
            sh_v_d  = cfg.cfg_v;
            state_d = CFG_PEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CFG_PEND: begin
        if (frame_wrap) begin
          act_h_d = sh_h_q;
          act_v_d = sh_v_q;
          state_d = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  // Configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CFG_IDLE;
      act_h_q <= H_DEF;
      act_v_q <= V_DEF;
      sh_h_q  <= H_DEF;
      sh_v_q  <= V_DEF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_h_q <= act_h_d;
      act_v_q <= act_v_d;
      sh_h_q  <= sh_h_d;
      sh_v_q  <= sh_v_d;
      err_q   <= err_d;
    end
  end

  // Next raster position and its decode against the timing that will be active.
  always_comb begin
    hpos_d = h_last ? '0 : hpos_q + COORD_W'(1);
    vpos_d = vpos_q;
    if (h_last) begin
      vpos_d = v_last ? '0 : vpos_q + COORD_W'(1);
    end
    hp_n     = TW'(hpos_d);
    vp_n     = TW'(vpos_d);
    hs_start = fld(act_h_d, 3) + fld(act_h_d, 2);
    hs_end   = hs_start + fld(act_h_d, 1);
    vs_start = fld(act_v_d, 3) + fld(act_v_d, 2);
    vs_end   = vs_start + fld(act_v_d, 1);
    hs_act   = (hp_n >= hs_start) && (hp_n < hs_end);
    vs_act   = (vp_n >= vs_start) && (vp_n < vs_end);
  end

  // Raster registers; everything advances only on a pixel strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      disp_q  <= 1'b1;
      ls_q    <= 1'b1;
      fs_q    <= 1'b1;
    end else if (clk_stb_i) begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      disp_q  <= (hp_n < fld(act_h_d, 3)) && (vp_n < fld(act_v_d, 3));
      ls_q    <= (hpos_d == '0);
      fs_q    <= (hpos_d == '0) && (vpos_d == '0);
    end
  end

  assign cfg.cfg_ready = (state_q == CFG_IDLE);
  assign cfg.cfg_err   = err_q;
  assign hpos_o        = hpos_q;
  assign vpos_o        = vpos_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign display_on_o  = disp_q;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count_o = frame_cnt_q;
`endif

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter COORD_W, default 11: width of every coordinate, counter and timing field.
REQ-002 Parameters H_DISPLAY/H_FRONT/H_SYNC/H_BACK, defaults 640/16/96/48: reset-time horizontal timing, in pixels.
REQ-003 Parameters V_DISPLAY/V_BOTTOM/V_SYNC/V_TOP, defaults 480/10/2/33: reset-time vertical timing, in lines.
REQ-004 Parameters HSYNC_POL/VSYNC_POL, default 0/0: active level of hsync/vsync (0 = active-low).
REQ-005 clk  in  1  single clock; the block has one clock only.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 clk_stb  in  1  pixel strobe; timing advances only on cycles where it is high.
REQ-008 cfg_valid  in  1  new timing offered.
REQ-009 cfg_ready  out  1  block can accept a new timing.
REQ-010 cfg_h  in  4*COORD_W  {display, front, sync, back}, with display in the MSBs.
REQ-011 cfg_v  in  4*COORD_W  {display, bottom, sync, top}, with display in the MSBs.
REQ-012 cfg_err  out  1  one-cycle pulse: offered timing rejected.
REQ-013 hsync, vsync  out  1 each  sync outputs at the configured polarity.
REQ-014 display_on  out  1  pixel is in the active area.
REQ-015 hpos, vpos  out  COORD_W each  current pixel and line.
REQ-016 line_start, frame_start  out  1 each  first pixel of a line / of a frame.

Function
REQ-017 All outputs SHALL be registered and SHALL change only on clk_stb cycles (cfg_ready/cfg_err excepted).
REQ-018 On a strobe, hpos SHALL go to 0 if hpos == h_total-1, else hpos+1; h_total = display+front+sync+back of the active timing.
REQ-019 vpos SHALL advance only on the strobe where hpos wraps; it SHALL go to 0 if vpos == v_total-1, else vpos+1.
REQ-020 hsync, vsync, display_on, line_start and frame_start SHALL be decoded from the same next-state values loaded into hpos/vpos, so they are cycle-aligned with the coordinates.
REQ-021 hsync SHALL be active for display+front <= hpos < display+front+sync; vsync SHALL use the same rule on vpos with bottom in place of front.
REQ-022 display_on SHALL be high when hpos < display and vpos < display, each compared with its own axis's display value.
REQ-023 line_start SHALL be high for the pixel period where hpos == 0; frame_start SHALL be high for the pixel period where hpos == 0 and vpos == 0.
REQ-024 A cfg_valid && cfg_ready cycle SHALL capture cfg_h/cfg_v into a shadow register, and cfg_ready SHALL be low from the following cycle.
REQ-025 The shadow timing SHALL become active on the strobe that wraps both hpos and vpos, and cfg_ready SHALL return high on the next cycle.
REQ-026 A capture on the same cycle as a frame wrap SHALL take effect at the following frame wrap, not the current one.
REQ-027 An offer SHALL be rejected if any display or sync field is 0, or if h_total or v_total exceeds 2^COORD_W; a rejected offer SHALL raise cfg_err for one cycle, leave cfg_ready high, and leave the shadow register unchanged.
REQ-028 Totals SHALL be computed at COORD_W+2 bits so they cannot overflow.
REQ-029 With clk_stb held low, all state SHALL hold, except that a cfg capture or rejection still proceeds.

Reset
REQ-030 While reset is high, regardless of clk_stb, the block SHALL set:
- hpos = vpos = 0
- hsync and vsync inactive
- display_on = 1, line_start = 1, frame_start = 1
- cfg_ready = 1, cfg_err = 0
- active timing and shadow timing = parameter defaults, with any pending configuration discarded
REQ-031 If reset is asserted in the middle of a frame or while a configuration is pending, counting SHALL restart from (0,0) at the parameter timing on the first strobe after release.

Configuration
REQ-032 With VTG_FRAME_CNT_EN defined, the block SHALL provide an output frame_count (16 bits) that resets to 0, increments on every frame-wrap strobe, and wraps from 65535 to 0.
REQ-033 Without VTG_FRAME_CNT_EN, the frame_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Defaults with clk_stb = 1: hsync low for hpos 656..751; vsync low for vpos 490..491; line period 800 clocks; frame period 420000 clocks.
REQ-035 clk_stb high every 4th cycle: hpos increments exactly once per 4 clocks, and the frame period is 1680000 clocks.
REQ-036 Offer cfg_h = {800, 40, 128, 88} and cfg_v = {600, 1, 4, 23} mid-frame: cfg_ready drops, the old timing completes the frame, the next frame is 1056x628 pixels, and cfg_ready rises on the cycle after the wrap.
REQ-037 Offer cfg_h display = 0: cfg_err pulses for one cycle, cfg_ready stays 1, and the timing is unchanged.
REQ-038 HSYNC_POL = 1: hsync is high for hpos 656..751; reset asserted at vpos 300 returns all outputs to their reset values on the next cycle.
REQ-039 With VTG_FRAME_CNT_EN defined: after 3 frames frame_count = 3; preloaded with 65535, it reads 0 after the next frame wrap.
